// File: rtl/rr_arbiter.sv
// Round-robin arbiter: 2**N requesters, registered one-hot grant, rotating priority.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter #(
   parameter int unsigned N       = 3,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [(1<<N)-1:0]  req,
   input  logic               done,
   output logic [(1<<N)-1:0]  gnt,
   output logic [N-1:0]       gnt_id,
   output logic               gnt_valid,
   output logic               err,
   output logic               timeout
);

   localparam int unsigned M = 1 << N;
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   generate
      if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
         $error("rr_arbiter: TIMEOUT must lie in 2..65535");
      end
   endgenerate

   logic [0:0]   state_q, state_d;
   logic [N-1:0] ptr_q, ptr_d;
   logic [M-1:0] gnt_q, gnt_d;
   logic [N-1:0] gnt_id_q, gnt_id_d;
   logic         gnt_valid_q, gnt_valid_d;
   logic         err_q, err_d;
   logic         expire;
`ifdef ARB_TIMEOUT_EN
   logic [15:0]  cnt_q, cnt_d;
   logic         timeout_q, timeout_d;
`endif

   // rot_req[i] is requester (ptr+i) mod M, so bit 0 has highest priority
   logic [M-1:0] rot_req;
   generate
      for (genvar gi = 0; gi < M; gi++) begin : g_rot
         assign rot_req[gi] = req[ptr_q + N'(gi)];
      end
   endgenerate

   logic [N-1:0] win_off;
   logic         any_req;
   always_comb begin
      win_off = '0;
      any_req = 1'b0;
      for (int i = M - 1; i >= 0; i--) begin
         if (rot_req[i]) begin
            win_off = N'(i);
            any_req = 1'b1;
         end
      end
   end

   logic [N-1:0] winner;
   logic         release_now;
   assign winner      = ptr_q + win_off;
   assign release_now = done | ~req[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
   assign expire = (cnt_q == 16'(TIMEOUT - 1));
`else
   assign expire = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_d       = gnt_q;
      gnt_id_d    = gnt_id_q;
      gnt_valid_d = gnt_valid_q;
      err_d       = 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
      timeout_d   = 1'b0;
`endif
      if (state_q == IDLE) begin
         err_d = done;
         if (any_req) begin
            state_d        = GRANT;
            gnt_d          = '0;
            gnt_d[winner]  = 1'b1;
            gnt_id_d       = winner;
            gnt_valid_d    = 1'b1;
`ifdef ARB_TIMEOUT_EN
            cnt_d          = '0;
`endif
         end
      end else begin
         // Normal release wins over the watchdog when both hit the same edge
         if (release_now || expire) begin
            state_d     = IDLE;
            ptr_d       = gnt_id_q + N'(1);
            gnt_d       = '0;
            gnt_id_d    = '0;
            gnt_valid_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
            timeout_d   = expire & ~release_now;
            cnt_d       = '0;
`endif
         end else begin
`ifdef ARB_TIMEOUT_EN
            cnt_d = cnt_q + 16'd1;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         gnt_q       <= '0;
         gnt_id_q    <= '0;
         gnt_valid_q <= 1'b0;
         err_q       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         cnt_q       <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         gnt_id_q    <= gnt_id_d;
         gnt_valid_q <= gnt_valid_d;
         err_q       <= err_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q       <= cnt_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

   assign gnt       = gnt_q;
   assign gnt_id    = gnt_id_q;
   assign gnt_valid = gnt_valid_q;
   assign err       = err_q;
`ifdef ARB_TIMEOUT_EN
   assign timeout   = timeout_q;
`else
   assign timeout   = 1'b0;
`endif

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter: N, 3, requester index width; requester count is 2**N.
REQ-002 Parameter: TIMEOUT, 16, maximum grant length in cycles; legal range 2..65535; used only under ARB_TIMEOUT_EN.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  synchronous active-low reset, sampled on rising clk edge.
REQ-005 Port: req  input  2**N  request vector; bit i high = requester i wants the shared resource.
REQ-006 Port: done  input  1  single-cycle release strobe from the current owner.
REQ-007 Port: gnt  output  2**N  registered one-hot grant vector; all-zero when no owner.
REQ-008 Port: gnt_id  output  N  registered binary index of the owner; 0 when gnt_valid low.
REQ-009 Port: gnt_valid  output  1  registered; high exactly when gnt is non-zero.
REQ-010 Port: err  output  1  registered one-cycle pulse; done seen with no owner.
REQ-011 Port: timeout  output  1  registered one-cycle pulse; grant revoked by watchdog.

Function
REQ-012 FSM states: IDLE (no owner) and GRANT (one owner); no other states.
REQ-013 Round-robin pointer ptr (N bits) marks the highest-priority requester.
REQ-014 IDLE, req non-zero: select first set bit scanning ptr, ptr+1, ..., wrapping modulo 2**N; next edge: gnt = one-hot of winner, gnt_id = winner, gnt_valid = 1, state GRANT.
REQ-015 Latency: req sampled high at edge k yields gnt visible after edge k (one register stage); no combinational req-to-gnt path.
REQ-016 IDLE, req all-zero: outputs stay zero, ptr unchanged.
REQ-017 GRANT: grant held unchanged regardless of other req bits.
REQ-018 GRANT release: done high, or req[gnt_id] low, at an edge; that edge clears gnt/gnt_id/gnt_valid, sets ptr = (gnt_id+1) mod 2**N, returns to IDLE.
REQ-019 done and req[gnt_id] falling on the same edge is one release; ptr advances once.
REQ-020 Wrap: release of gnt_id = 2**N-1 sets ptr to 0.
REQ-021 At least one IDLE cycle separates consecutive grants; gnt_valid low for exactly one cycle between back-to-back grants when requests are pending.
REQ-022 done high in IDLE: ignored for state, err pulses high the following cycle; err otherwise 0.
REQ-023 gnt never has more than one bit set; gnt_id always equals the encoded index of gnt.
REQ-024 Fairness: a continuously asserting requester is granted within 2**N grants.

Reset
REQ-025 rst_n low at an edge: state IDLE, ptr 0, gnt 0, gnt_id 0, gnt_valid 0, err 0, timeout 0, watchdog count 0.
REQ-026 Reset during GRANT revokes the grant at that edge with no timeout or err pulse; the first post-reset grant starts its search from requester 0.
REQ-027 Inputs ignored while rst_n low.

Configuration
REQ-028 Macro ARB_TIMEOUT_EN: when defined, a cycle counter clears on entry to GRANT and increments each GRANT cycle; if the grant is not released when the count reaches TIMEOUT-1, the next edge forces release per REQ-018 (ptr advances) and pulses timeout for one cycle.
REQ-029 Normal release on the same edge as the watchdog expiry takes precedence; timeout stays 0.
REQ-030 Without ARB_TIMEOUT_EN: no counter logic; timeout tied to 0; grants held indefinitely.

Verification
REQ-031 Reset, then req=8'b0000_0100 -> one cycle later gnt=8'b0000_0100, gnt_id=2, gnt_valid=1.
REQ-032 req=8'hFF held, done pulsed each grant -> gnt_id sequence 0,1,2,...,7,0, with one idle cycle between each grant.
REQ-033 Owner 7 released, req=8'b1000_0001 -> next grant goes to 0 (ptr wrap).
REQ-034 done pulsed with gnt_valid=0 -> err=1 for one cycle, gnt stays 0.
REQ-035 ARB_TIMEOUT_EN, TIMEOUT=4, req=8'b0000_0010 held, no done -> gnt released after 4 GRANT cycles, timeout=1 one cycle, regrant to 1 after one IDLE cycle; macro undefined -> grant held, timeout=0.
REQ-036 rst_n low mid-GRANT with gnt_id=5 -> next cycle all outputs 0; with req=8'hFF afterward, first grant gnt_id=0.
